// File: rtl/fft_scale_ctrl.sv
// fft_scale_ctrl: block-floating-point shift scheduler for a radix-2 FFT
module fft_scale_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int N_POINTS   = 64,
  parameter int N_STAGES   = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    sample_valid,
  input  logic [2*DATA_WIDTH-1:0] sample_in,
  output logic                    busy,
  output logic [2:0]              stage_idx,
  output logic [1:0]              stage_shift,
  output logic [3:0]              exp_out,
  output logic                    stage_done,
  output logic                    done
);
  localparam int CW = (N_POINTS > 1) ? $clog2(N_POINTS) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0] mx, mx_n, cls_re, cls_im, cur;
  logic [2:0] stage_idx_n;
  logic [1:0] stage_shift_n;
  logic [3:0] exp_n;
  logic busy_n, stage_done_n, done_n, last, final_stage, unused_lo;
  // headroom class from the three top bits: 2 = top bit already lost, 1 = one guard bit left
  function automatic logic [1:0] cls(input logic [2:0] t);
    return (t[2] != t[1]) ? 2'd2 : (t[1] != t[0]) ? 2'd1 : 2'd0;
  endfunction
  assign cls_re      = cls(sample_in[2*DATA_WIDTH-1 -: 3]);
  assign cls_im      = cls(sample_in[DATA_WIDTH-1 -: 3]);
  assign unused_lo   = ^{sample_in[2*DATA_WIDTH-4:DATA_WIDTH], sample_in[DATA_WIDTH-4:0]};
  assign cur         = (cls_re > cls_im) ? ((cls_re > mx) ? cls_re : mx) : ((cls_im > mx) ? cls_im : mx);
  assign last        = sample_valid && cnt == CW'(N_POINTS - 1);
  assign final_stage = stage_idx == 3'(N_STAGES - 1);
  // state and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      mx          <= '0;
      busy        <= 1'b0;
      stage_idx   <= '0;
      stage_shift <= '0;
      exp_out     <= '0;
      stage_done  <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      mx          <= mx_n;
      busy        <= busy_n;
      stage_idx   <= stage_idx_n;
      stage_shift <= stage_shift_n;
      exp_out     <= exp_n;
      stage_done  <= stage_done_n;
      done        <= done_n;
    end
  // next state: start only honoured in IDLE, DONE always falls back to IDLE
  always_comb
    state_n = (state == IDLE && start) ? RUN :
              (state == RUN && last && final_stage) ? DONE :
              (state == DONE) ? IDLE : state;
  // next outputs: stage boundary commits the stage maximum as the next shift
  always_comb begin
    busy_n        = state_n == RUN;
    cnt_n         = cnt;
    mx_n          = mx;
    stage_idx_n   = stage_idx;
    stage_shift_n = stage_shift;
    exp_n         = exp_out;
    stage_done_n  = 1'b0;
    done_n        = 1'b0;
    if (state == IDLE && start) begin
      cnt_n         = '0;
      mx_n          = '0;
      stage_idx_n   = '0;
      stage_shift_n = '0;
      exp_n         = '0;
    end else if (state == RUN && sample_valid) begin
      cnt_n = last ? '0 : cnt + 1'b1;
      mx_n  = last ? 2'd0 : cur;
      done_n = last && final_stage;
      stage_done_n = last && !final_stage;
      stage_shift_n = stage_done_n ? cur : stage_shift;
      exp_n = stage_done_n ? exp_out + {2'b00, cur} : exp_out;
      stage_idx_n = stage_done_n ? stage_idx + 3'd1 : stage_idx;
    end
  end
endmodule

// File: tb/tb_fft_scale_ctrl.sv
// tb_fft_scale_ctrl: directed checks of the FFT scaling controller
module tb_fft_scale_ctrl;
  logic clk = 1'b0;
  logic rst, start, sample_valid;
  logic [31:0] sample_in;
  logic busy, stage_done, done;
  logic [2:0] stage_idx;
  logic [1:0] stage_shift;
  logic [3:0] exp_out;
  int total = 0, bad = 0, cyc, gi, nsd, ndn, dn_at;
  int sd_at[8];
  logic [1:0] sh[8];
  logic [3:0] ex[8];
  logic [1:0] esh[5] = '{2'd1, 2'd1, 2'd2, 2'd0, 2'd0};
  logic [3:0] eex[5] = '{4'd1, 4'd2, 4'd4, 4'd4, 4'd4};

  fft_scale_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid), .sample_in(sample_in),
    .busy(busy), .stage_idx(stage_idx), .stage_shift(stage_shift), .exp_out(exp_out),
    .stage_done(stage_done), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] pat(input int mode, input int i);
    if (mode == 1) return i == 0 ? 32'h2000_0010 : i == 64 ? 32'h0010_D000 : i == 138 ? 32'h5000_0010 : 32'h0010_0010;
    if (mode == 2) return i == 63 ? 32'h5000_0010 : 32'hE000_E000;
    return 32'h0010_0010;
  endfunction

  task automatic step(input logic v, input logic [31:0] s);
    sample_valid = v;
    sample_in = s;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (stage_done) begin
      if (nsd < 8) begin
        sd_at[nsd] = cyc;
        sh[nsd] = stage_shift;
        ex[nsd] = exp_out;
      end
      nsd++;
    end
    if (done) begin
      ndn++;
      dn_at = cyc;
    end
  endtask

  task automatic clear();
    cyc = 0; gi = 0; nsd = 0; ndn = 0; dn_at = 0;
  endtask

  task automatic feed(input int n, input int mode, input bit gap);
    for (int i = 0; i < n; i++) begin
      step(1'b1, pat(mode, gi));
      gi++;
      if (gap) step(1'b0, 32'h5000_5000);
    end
    sample_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step(1'b0, 32'h0);
    start = 1'b0;
    clear();
  endtask

  task automatic zero_chk(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_idx"}, stage_idx, 0);
    chk({tag, "_shift"}, stage_shift, 0);
    chk({tag, "_exp"}, exp_out, 0);
    chk({tag, "_sdone"}, stage_done, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic check_pattern(input string tag, input int pitch, input int off, input int dn_cyc);
    chk({tag, "_nsd"}, nsd, 5);
    chk({tag, "_ndone"}, ndn, 1);
    chk({tag, "_done_at"}, dn_at, dn_cyc);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("%s_sh%0d", tag, k), sh[k], esh[k]);
      chk($sformatf("%s_ex%0d", tag, k), ex[k], eex[k]);
      chk($sformatf("%s_at%0d", tag, k), sd_at[k], pitch * (k + 1) - off);
    end
    chk({tag, "_final_exp"}, exp_out, 4);
    chk({tag, "_final_shift"}, stage_shift, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sample_valid = 1'b0; sample_in = '0;
    clear();
    @(negedge clk); @(negedge clk);
    zero_chk("reset");
    rst = 1'b0;
    @(negedge clk);

    // small samples: no shifts anywhere, five stage pulses, done after sample 384
    do_start();
    chk("A_busy", busy, 1);
    feed(384, 0, 1'b0);
    chk("A_nsd", nsd, 5);
    chk("A_ndone", ndn, 1);
    chk("A_done_at", dn_at, 384);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("A_sh%0d", k), sh[k], 0);
      chk($sformatf("A_at%0d", k), sd_at[k], 64 * (k + 1));
    end
    chk("A_done_busy", busy, 0);
    step(1'b0, 32'h0);
    chk("A_done_pulse", done, 0);
    chk("A_exp", exp_out, 0);

    // valid samples in IDLE are ignored
    for (int i = 0; i < 70; i++) step(1'b1, 32'h5000_5000);
    sample_valid = 1'b0;
    chk("idle_nsd", nsd, 5);
    chk("idle_busy", busy, 0);
    chk("idle_shift", stage_shift, 0);

    // headroom hits in stages 0..2, no gaps
    do_start();
    chk("B_start_exp", exp_out, 0);
    feed(384, 1, 1'b0);
    check_pattern("B", 64, 0, 384);
    step(1'b0, 32'h0);
    chk("B_hold_exp", exp_out, 4);

    // same pattern with sample_valid alternating
    do_start();
    chk("D_start_exp", exp_out, 0);
    feed(384, 1, 1'b1);
    check_pattern("D", 128, 1, 767);

    // 0xE000 is class 0; boundary sample still counts
    do_start();
    feed(128, 2, 1'b0);
    chk("C_nsd", nsd, 2);
    chk("C_sh0", sh[0], 2);
    chk("C_sh1", sh[1], 0);
    chk("C_exp", exp_out, 2);
    chk("C_idx", stage_idx, 2);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 zero_chk("C_async_rst");
    @(negedge clk);
    rst = 1'b0;

    // start ignored mid-run, reset in stage 3 abandons, restart from zero
    do_start();
    feed(133, 1, 1'b0);
    start = 1'b1;
    feed(1, 1, 1'b0);
    start = 1'b0;
    chk("E_idx_mid", stage_idx, 2);
    chk("E_busy_mid", busy, 1);
    feed(58, 1, 1'b0);
    chk("E_nsd", nsd, 3);
    chk("E_idx3", stage_idx, 3);
    chk("E_shift", stage_shift, 2);
    chk("E_exp", exp_out, 4);
    feed(10, 1, 1'b0);
    #2 rst = 1'b1;
    #1 zero_chk("E_rst");
    @(negedge clk);
    rst = 1'b0;
    clear();
    for (int i = 0; i < 20; i++) step(1'b1, 32'h0010_0010);
    sample_valid = 1'b0;
    chk("E_no_done", ndn, 0);
    chk("E_idle_busy", busy, 0);
    do_start();
    chk("E_re_busy", busy, 1);
    chk("E_re_idx", stage_idx, 0);
    chk("E_re_exp", exp_out, 0);
    feed(64, 0, 1'b0);
    chk("E_re_nsd", nsd, 1);
    chk("E_re_idx1", stage_idx, 1);
    chk("E_re_exp1", exp_out, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
